// File: rtl/standby_pkg.sv
// ============================================================================
//  Module  : standby_pkg
//  Purpose : Shared state codes, segment constants and BCD segment table.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package standby_pkg;

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_BLINK = 2'd1;
   localparam logic [1:0] ST_STAY  = 2'd2;
   localparam logic [1:0] ST_SLEEP = 2'd3;

   localparam logic [6:0] SEG_ALL   = 7'h7F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Segment order is {g,f,e,d,c,b,a}; non-decimal codes stay dark.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/standby_sequencer_seg7_decode.sv
// ============================================================================
//  Module  : seg7_decode
//  Purpose : Combinational 4-bit BCD to 7-segment decoder, blank above 9.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decode
   import standby_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = bcd_to_seg(code);
   end

endmodule

`default_nettype wire

// File: rtl/standby_sequencer.sv
// ============================================================================
//  Module  : standby_sequencer
//  Purpose : Power-on blink sequence, then multiplexed BCD display.
//            Optional SLEEP timeout enabled by `STANDBY_TIMEOUT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module standby_sequencer
   import standby_pkg::*;
#(
   parameter int DIGITS        = 8,
   parameter int BLINK_TOGGLES = 8,
   parameter int TIMEOUT_TICKS = 120
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  blink_tick,
   input  logic                  scan_tick,
   input  logic                  power_sw,
   input  logic [4*DIGITS-1:0]   digit_data,
   input  logic [DIGITS-1:0]     force_on,
   input  logic                  activity,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     tube,
   output logic                  running,
   output logic                  stay,
   output logic                  sleep
);

   localparam int CNT_W  = $clog2(BLINK_TOGGLES + 1);
   localparam int SCAN_W = $clog2(DIGITS);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_TOGGLES - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGITS - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              phase_q, phase_d;
   logic [SCAN_W-1:0] scan_idx_q, scan_idx_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] tube_q, tube_d;
   logic              running_q, running_d;
   logic              stay_q, stay_d;
   logic              sleep_q, sleep_d;
   logic [6:0]        stay_seg;

`ifdef STANDBY_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_TICKS - 1);
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = &{1'b0, activity, TIMEOUT_TICKS[0]};
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;
      scan_idx_d = scan_idx_q;
`ifdef STANDBY_TIMEOUT_EN
      tcnt_d     = tcnt_q;
`endif
      if (!power_sw) begin
         state_d    = ST_OFF;
         cnt_d      = '0;
         phase_d    = 1'b0;
         scan_idx_d = '0;
`ifdef STANDBY_TIMEOUT_EN
         tcnt_d     = '0;
`endif
      end else begin
         if (state_q != ST_OFF && scan_tick) begin
            scan_idx_d = (scan_idx_q == SCAN_LAST) ? '0 : scan_idx_q + 1'b1;
         end
         case (state_q)
            ST_OFF: begin
               state_d = ST_BLINK;
               cnt_d   = '0;
               phase_d = 1'b0;
            end
            ST_BLINK: begin
               if (blink_tick) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d = ST_STAY;
                     cnt_d   = '0;
                     phase_d = 1'b0;
`ifdef STANDBY_TIMEOUT_EN
                     tcnt_d  = '0;
`endif
                  end else begin
                     cnt_d   = cnt_q + 1'b1;
                     phase_d = ~phase_q;
                  end
               end
            end
            ST_STAY: begin
`ifdef STANDBY_TIMEOUT_EN
               // Activity outranks a coincident blink_tick.
               if (activity) begin
                  tcnt_d = '0;
               end else if (blink_tick) begin
                  tcnt_d = tcnt_q + 1'b1;
                  if (tcnt_q == TCNT_LAST) begin
                     state_d = ST_SLEEP;
                  end
               end
`endif
            end
`ifdef STANDBY_TIMEOUT_EN
            ST_SLEEP: begin
               if (activity) begin
                  state_d = ST_STAY;
                  tcnt_d  = '0;
               end
            end
`endif
            default: state_d = ST_OFF;
         endcase
      end
   end

   seg7_decode u_decode (
      .code (digit_data[{scan_idx_d, 2'b00} +: 4]),
      .seg  (stay_seg)
   );

   // Outputs are derived from next-state values so they register together with the FSM.
   always_comb begin
      seg_d     = SEG_BLANK;
      tube_d    = '1;
      running_d = (state_d == ST_BLINK);
      stay_d    = (state_d == ST_STAY) || (state_d == ST_SLEEP);
      sleep_d   = (state_d == ST_SLEEP);
      case (state_d)
         ST_BLINK: begin
            seg_d = SEG_ALL;
            if (phase_d || force_on[scan_idx_d]) begin
               tube_d[scan_idx_d] = 1'b0;
            end
         end
         ST_STAY: begin
            seg_d              = stay_seg;
            tube_d[scan_idx_d] = 1'b0;
         end
         default: begin
            seg_d  = SEG_BLANK;
            tube_d = '1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_OFF;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         scan_idx_q <= '0;
         seg_q      <= SEG_BLANK;
         tube_q     <= '1;
         running_q  <= 1'b0;
         stay_q     <= 1'b0;
         sleep_q    <= 1'b0;
`ifdef STANDBY_TIMEOUT_EN
         tcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         scan_idx_q <= scan_idx_d;
         seg_q      <= seg_d;
         tube_q     <= tube_d;
         running_q  <= running_d;
         stay_q     <= stay_d;
         sleep_q    <= sleep_d;
`ifdef STANDBY_TIMEOUT_EN
         tcnt_q     <= tcnt_d;
`endif
      end
   end

   assign seg     = seg_q;
   assign tube    = tube_q;
   assign running = running_q;
   assign stay    = stay_q;
   assign sleep   = sleep_q;

endmodule

`default_nettype wire

// File: tb/tb_standby_sequencer.sv
// ============================================================================
//  Module  : tb_standby_sequencer
//  Purpose : Directed self-checking bench for standby_sequencer (8 digits).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_standby_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        blink_tick;
   logic        scan_tick;
   logic        power_sw;
   logic [31:0] digit_data;
   logic [7:0]  force_on;
   logic        activity;
   logic [6:0]  seg;
   logic [7:0]  tube;
   logic        running;
   logic        stay;
   logic        sleep;

   int checks   = 0;
   int failures = 0;

   // {running, stay, sleep, tube, seg}
   logic [17:0] obs;
   assign obs = {running, stay, sleep, tube, seg};

   // Segment codes for digit_data = 32'h9876_5432, indexed by digit
   logic [6:0] seg_tab [8] = '{7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   standby_sequencer #(
      .DIGITS        (8),
      .BLINK_TOGGLES (8),
      .TIMEOUT_TICKS (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .blink_tick (blink_tick),
      .scan_tick  (scan_tick),
      .power_sw   (power_sw),
      .digit_data (digit_data),
      .force_on   (force_on),
      .activity   (activity),
      .seg        (seg),
      .tube       (tube),
      .running    (running),
      .stay       (stay),
      .sleep      (sleep)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_blink();
      blink_tick = 1'b1;
      cyc();
      blink_tick = 1'b0;
   endtask

   task automatic tick_scan();
      scan_tick = 1'b1;
      cyc();
      scan_tick = 1'b0;
   endtask

   task automatic go_stay();
      power_sw = 1'b0;
      cyc();
      power_sw = 1'b1;
      cyc();
      for (int k = 0; k < 8; k++) tick_blink();
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      blink_tick = 1'b0;
      scan_tick  = 1'b0;
      power_sw   = 1'b0;
      digit_data = 32'h9876_5432;
      force_on   = 8'h00;
      activity   = 1'b0;
      cyc();
      cyc();
      checks++;
      if (obs !== {3'b000, 8'hFF, 7'h00}) begin
         failures++;
         $display("FAIL reset: got %h expected %h", obs, {3'b000, 8'hFF, 7'h00});
      end
      rst_n = 1'b1;
      cyc();
      checks++;
      if (obs !== {3'b000, 8'hFF, 7'h00}) begin
         failures++;
         $display("FAIL off_idle: got %h expected %h", obs, {3'b000, 8'hFF, 7'h00});
      end
   endtask

   task automatic test_blink();
      logic [17:0] exp;
      power_sw = 1'b1;
      cyc();
      checks++;
      if (obs !== {3'b100, 8'hFF, 7'h7F}) begin
         failures++;
         $display("FAIL blink_entry: got %h expected %h", obs, {3'b100, 8'hFF, 7'h7F});
      end
      for (int k = 1; k <= 8; k++) begin
         tick_blink();
         if (k < 8) exp = {3'b100, ((k % 2) == 1) ? 8'hFE : 8'hFF, 7'h7F};
         else       exp = {3'b010, 8'hFE, 7'h5B};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL blink_tick%0d: got %h expected %h", k, obs, exp);
         end
      end
   endtask

   task automatic test_stay_scan();
      logic [17:0] exp;
      int idx;
      for (int i = 1; i <= 10; i++) begin
         tick_scan();
         idx = i % 8;
         exp = {3'b010, 8'hFF ^ (8'h01 << idx), seg_tab[idx]};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL stay_scan%0d: got %h expected %h", i, obs, exp);
         end
      end
      // digit 2 becomes a non-decimal code: blank segments, tube still on
      digit_data = 32'h9876_5C32;
      cyc();
      checks++;
      if (obs !== {3'b010, 8'hFB, 7'h00}) begin
         failures++;
         $display("FAIL stay_nonbcd: got %h expected %h", obs, {3'b010, 8'hFB, 7'h00});
      end
      digit_data = 32'h9876_5432;
   endtask

   task automatic test_force_on();
      logic [17:0] exp;
      power_sw = 1'b0;
      cyc();
      checks++;
      if (obs !== {3'b000, 8'hFF, 7'h00}) begin
         failures++;
         $display("FAIL power_off: got %h expected %h", obs, {3'b000, 8'hFF, 7'h00});
      end
      power_sw = 1'b1;
      force_on = 8'h08;
      cyc();
      for (int i = 1; i <= 4; i++) begin
         tick_scan();
         exp = {3'b100, (i == 3) ? 8'hF7 : 8'hFF, 7'h7F};
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL force_on_idx%0d: got %h expected %h", i, obs, exp);
         end
      end
      tick_blink();
      checks++;
      if (obs !== {3'b100, 8'hEF, 7'h7F}) begin
         failures++;
         $display("FAIL force_phase1: got %h expected %h", obs, {3'b100, 8'hEF, 7'h7F});
      end
      force_on = 8'h00;
      power_sw = 1'b0;
      cyc();
   endtask

   task automatic test_power_drop();
      power_sw = 1'b1;
      cyc();
      tick_scan();
      tick_scan();
      for (int k = 0; k < 4; k++) tick_blink();
      power_sw   = 1'b0;
      blink_tick = 1'b1;
      cyc();
      blink_tick = 1'b0;
      checks++;
      if (obs !== {3'b000, 8'hFF, 7'h00}) begin
         failures++;
         $display("FAIL drop_off: got %h expected %h", obs, {3'b000, 8'hFF, 7'h00});
      end
      power_sw = 1'b1;
      cyc();
      checks++;
      if (obs !== {3'b100, 8'hFF, 7'h7F}) begin
         failures++;
         $display("FAIL drop_reblink: got %h expected %h", obs, {3'b100, 8'hFF, 7'h7F});
      end
      for (int k = 0; k < 7; k++) tick_blink();
      checks++;
      if (obs !== {3'b100, 8'hFE, 7'h7F}) begin
         failures++;
         $display("FAIL drop_tick7: got %h expected %h", obs, {3'b100, 8'hFE, 7'h7F});
      end
      tick_blink();
      checks++;
      if (obs !== {3'b010, 8'hFE, 7'h5B}) begin
         failures++;
         $display("FAIL drop_tick8: got %h expected %h", obs, {3'b010, 8'hFE, 7'h5B});
      end
   endtask

   task automatic test_async_reset();
      tick_scan();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== {3'b000, 8'hFF, 7'h00}) begin
         failures++;
         $display("FAIL async_reset: got %h expected %h", obs, {3'b000, 8'hFF, 7'h00});
      end
      cyc();
      rst_n = 1'b1;
      cyc();
      checks++;
      if (obs !== {3'b100, 8'hFF, 7'h7F}) begin
         failures++;
         $display("FAIL post_reset_blink: got %h expected %h", obs, {3'b100, 8'hFF, 7'h7F});
      end
   endtask

`ifdef STANDBY_TIMEOUT_EN
   task automatic test_timeout();
      go_stay();
      for (int k = 0; k < 3; k++) tick_blink();
      checks++;
      if (obs !== {3'b010, 8'hFE, 7'h5B}) begin
         failures++;
         $display("FAIL tmo_before: got %h expected %h", obs, {3'b010, 8'hFE, 7'h5B});
      end
      tick_blink();
      checks++;
      if (obs !== {3'b011, 8'hFF, 7'h00}) begin
         failures++;
         $display("FAIL tmo_sleep: got %h expected %h", obs, {3'b011, 8'hFF, 7'h00});
      end
      activity = 1'b1;
      cyc();
      activity = 1'b0;
      checks++;
      if (obs !== {3'b010, 8'hFE, 7'h5B}) begin
         failures++;
         $display("FAIL tmo_wake: got %h expected %h", obs, {3'b010, 8'hFE, 7'h5B});
      end
      for (int k = 0; k < 3; k++) tick_blink();
      activity   = 1'b1;
      blink_tick = 1'b1;
      cyc();
      activity   = 1'b0;
      blink_tick = 1'b0;
      for (int k = 0; k < 3; k++) tick_blink();
      checks++;
      if (obs !== {3'b010, 8'hFE, 7'h5B}) begin
         failures++;
         $display("FAIL tmo_act_wins: got %h expected %h", obs, {3'b010, 8'hFE, 7'h5B});
      end
      tick_blink();
      checks++;
      if (obs !== {3'b011, 8'hFF, 7'h00}) begin
         failures++;
         $display("FAIL tmo_sleep2: got %h expected %h", obs, {3'b011, 8'hFF, 7'h00});
      end
   endtask
`else
   task automatic test_no_timeout();
      go_stay();
      for (int k = 0; k < 6; k++) begin
         activity = k[0];
         tick_blink();
      end
      activity = 1'b0;
      checks++;
      if (obs !== {3'b010, 8'hFE, 7'h5B}) begin
         failures++;
         $display("FAIL no_timeout: got %h expected %h", obs, {3'b010, 8'hFE, 7'h5B});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_blink();
      test_stay_scan();
      test_force_on();
      test_power_drop();
      test_async_reset();
`ifdef STANDBY_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
